// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative radix-2 multiply/divide engine for the EX stage. It runs signed and
//   unsigned 32x32 multiply (shift-add) and divide (restoring) on operand
//   magnitudes. Signs are applied in a single FIXUP cycle. The {Hi,Lo} result
//   feeds ALU64ResultIn of the EX/MEM register.
//
//   Ports
//     Clk             rising-edge clock
//     Rst_n           asynchronous active-low reset
//     StartIn         start request, honoured only in IDLE or DONE
//     OpIn[1:0]       00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with StartIn)
//     AIn, BIn        multiplicand/dividend, multiplier/divisor
//     FlushIn         synchronous abort; wins over StartIn
//     BusyOut         high in BUSY and FIXUP (pipeline stall request)
//     DoneOut         one-cycle pulse while in DONE
//     ALU64ResultOut  {Hi,Lo}; holds the last completed result
//     DivByZeroOut    set with DoneOut for a zero divisor, cleared on next accept
//
//   Build option
//     MULDIV_EARLY_OUT_EN  multiplies leave BUSY once the remaining multiplier
//                          bits are zero, and a final alignment shift is applied.
module ex_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                StartIn,
  input  logic [1:0]          OpIn,
  input  logic [DATA_W-1:0]   AIn,
  input  logic [DATA_W-1:0]   BIn,
  input  logic                FlushIn,
  output logic                BusyOut,
  output logic                DoneOut,
  output logic [2*DATA_W-1:0] ALU64ResultOut,
  output logic                DivByZeroOut
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;
  state_t state, stateNext;

  logic                isDivReg;
  logic [DATA_W-1:0]   aRaw;     // dividend as presented, for the divide-by-zero Hi
  logic [DATA_W-1:0]   magA;     // multiplicand magnitude / quotient shift register
  logic [DATA_W-1:0]   magB;     // multiplier shift register / divisor magnitude
  logic                signNeg;  // product and quotient share the sign A^B
  logic                remNeg;
  logic [2*DATA_W-1:0] acc;      // product; upper half doubles as the remainder
  logic [CNT_W-1:0]    cnt;

  logic                accept, lastIter, earlyExit, qBit, divZero;
  logic [DATA_W:0]     mulSum, remShift;
  logic [DATA_W+1:0]   trial;
  logic [2*DATA_W-1:0] prodAligned, mulResult, divResult;

  function automatic logic [DATA_W-1:0] absVal(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] negW(input logic [DATA_W-1:0] v);
    return -v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg2W(input logic [2*DATA_W-1:0] v);
    return -v;
  endfunction

  assign accept   = ((state == IDLE) || (state == DONE)) && StartIn && !FlushIn;
  assign lastIter = &cnt;
  assign BusyOut  = (state == BUSY) || (state == FIXUP);
  assign DoneOut  = (state == DONE);

`ifdef MULDIV_EARLY_OUT_EN
  // The multiplier is consumed LSB-first, so once only its LSB remains this is
  // the last iteration that can add anything.
  assign earlyExit = !isDivReg && (magB[DATA_W-1:1] == '0);
`else
  assign earlyExit = 1'b0;
`endif

  // One shift-add step: the carry out of the upper half is kept as the new MSB.
  assign mulSum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (magB[0] ? {1'b0, magA} : '0);
  // One restoring-divide step: shift the next dividend bit in, trial-subtract.
  assign remShift = {acc[2*DATA_W-1:DATA_W], magA[DATA_W-1]};
  assign trial    = {1'b0, remShift} - {2'b00, magB};
  assign qBit     = ~trial[DATA_W+1];

  always_comb begin
    prodAligned = acc;
`ifdef MULDIV_EARLY_OUT_EN
    // After k iterations the partial product sits k bits short of its final
    // position. A zero counter means all DATA_W iterations ran (it wrapped).
    if (cnt != '0)
      prodAligned = acc >> ((CNT_W+1)'(DATA_W) - {1'b0, cnt});
`endif
    mulResult = signNeg ? neg2W(prodAligned) : prodAligned;
    divZero   = (magB == '0);
    if (divZero)
      divResult = {aRaw, {DATA_W{1'b1}}};
    else
      divResult = {remNeg  ? negW(acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W],
                   signNeg ? negW(magA) : magA};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (FlushIn) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (StartIn) stateNext = BUSY;
        BUSY:    if (lastIter || earlyExit) stateNext = FIXUP;
        FIXUP:   stateNext = DONE;
        DONE:    stateNext = StartIn ? BUSY : IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      isDivReg       <= 1'b0;
      aRaw           <= '0;
      magA           <= '0;
      magB           <= '0;
      signNeg        <= 1'b0;
      remNeg         <= 1'b0;
      acc            <= '0;
      cnt            <= '0;
      ALU64ResultOut <= '0;
      DivByZeroOut   <= 1'b0;
    end else if (accept) begin
      isDivReg     <= OpIn[1];
      aRaw         <= AIn;
      magA         <= OpIn[0] ? AIn : absVal(AIn);
      magB         <= OpIn[0] ? BIn : absVal(BIn);
      signNeg      <= !OpIn[0] && (AIn[DATA_W-1] ^ BIn[DATA_W-1]);
      remNeg       <= !OpIn[0] && AIn[DATA_W-1];
      acc          <= '0;
      cnt          <= '0;
      DivByZeroOut <= 1'b0;
    end else if (state == BUSY && !FlushIn) begin
      cnt <= cnt + 1'b1;
      if (isDivReg) begin
        acc[2*DATA_W-1:DATA_W] <= qBit ? trial[DATA_W-1:0] : remShift[DATA_W-1:0];
        magA                   <= {magA[DATA_W-2:0], qBit};
      end else begin
        acc  <= {mulSum, acc[DATA_W-1:1]};
        magB <= magB >> 1;
      end
    end else if (state == FIXUP && !FlushIn) begin
      ALU64ResultOut <= isDivReg ? divResult : mulResult;
      DivByZeroOut   <= isDivReg && divZero;
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit. Expected results go into a scoreboard
// queue when an operation is started and are popped when DoneOut is seen.
// Latency is counted in rising edges from the accept edge (which counts as 1)
// through the edge that enters DONE.
module tb_ex_muldiv_unit;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        StartIn = 1'b0;
  logic        FlushIn = 1'b0;
  logic [1:0]  OpIn = 2'b00;
  logic [31:0] AIn = '0;
  logic [31:0] BIn = '0;
  logic        BusyOut, DoneOut, DivByZeroOut;
  logic [63:0] ALU64ResultOut;

  int total = 0;
  int bad = 0;
  logic [63:0] lastRes = '0;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb[$];

  ex_muldiv_unit #(.DATA_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .StartIn(StartIn), .OpIn(OpIn), .AIn(AIn), .BIn(BIn),
    .FlushIn(FlushIn), .BusyOut(BusyOut), .DoneOut(DoneOut),
    .ALU64ResultOut(ALU64ResultOut), .DivByZeroOut(DivByZeroOut)
  );

  always #5 Clk = ~Clk;

  function automatic int expLat(input logic [1:0] op, input logic [31:0] b);
    int bl;
    logic [31:0] m;
    bl = 0;
    m = (op == 2'b00 && b[31]) ? -b : b;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
    if (bl < 1) bl = 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) return 2 + bl;
`endif
    return 34;
  endfunction

  // Reference model: {divByZero, Hi, Lo}
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa_l, sb_l;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    case (op)
      2'b00: return {1'b0, 64'(sa_l * sb_l)};
      2'b01: return {1'b0, {32'd0, a} * {32'd0, b}};
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, 32'(sa_l % sb_l), 32'(sa_l / sb_l)};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Called #1 after an edge; returns #1 after the accept edge with operands scrambled.
  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res, input logic dbz, input string name);
    sb.push_back('{res, dbz, expLat(op, b), name});
    OpIn = op; AIn = a; BIn = b; StartIn = 1'b1;
    @(posedge Clk); #1;
    StartIn = 1'b0; AIn = $urandom; BIn = $urandom; OpIn = 2'($urandom);
  endtask

  task automatic collect(input int startLat, output logic [63:0] res, output logic dbz,
                         output int lat, output int busy);
    lat = startLat;
    busy = 0;
    while (!DoneOut && lat < 200) begin
      if (BusyOut) busy++;
      @(posedge Clk); #1;
      lat++;
    end
    res = ALU64ResultOut;
    dbz = DivByZeroOut;
  endtask

  task automatic test_reset();
    #1 Rst_n = 1'b0;
    #2;
    total++;
    if ({BusyOut, DoneOut, DivByZeroOut, ALU64ResultOut} !== 67'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {BusyOut, DoneOut, DivByZeroOut, ALU64ResultOut});
    end
    StartIn = 1'b1;
    @(posedge Clk); #1;
    total++;
    if (BusyOut !== 1'b0) begin bad++; $display("FAIL reset_holds_idle got=%b want=0", BusyOut); end
    StartIn = 1'b0;
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_multu();
    exp_t e; logic [63:0] r; logic z; int lat, busy;
    drive_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, "multu_max");
    collect(1, r, z, lat, busy);
    e = sb.pop_front();
    total++; if (r !== e.res) begin bad++; $display("FAIL %s_result got=%h want=%h", e.name, r, e.res); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", e.name, lat, e.lat); end
    total++; if (busy !== 33) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=33", e.name, busy); end
    lastRes = e.res;
    @(posedge Clk); #1;
    total++; if (DoneOut !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b want=0", DoneOut); end
  endtask

  task automatic test_mult();
    exp_t e; logic [63:0] r; logic z; int lat, busy;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive_op(2'b00, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0, "mult_neg");
      else        drive_op(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, "mult_minmin");
      collect(1, r, z, lat, busy);
      e = sb.pop_front();
      total++; if (r !== e.res) begin bad++; $display("FAIL %s_result got=%h want=%h", e.name, r, e.res); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", e.name, lat, e.lat); end
      lastRes = e.res;
    end
  endtask

  task automatic test_div();
    exp_t e; logic [63:0] r; logic z; int lat, busy;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive_op(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, "div_neg");
        1:       drive_op(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "divu_100_7");
        default: drive_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, "div_ovf");
      endcase
      collect(1, r, z, lat, busy);
      e = sb.pop_front();
      total++; if (r !== e.res) begin bad++; $display("FAIL %s_result got=%h want=%h", e.name, r, e.res); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", e.name, lat, e.lat); end
      total++; if (z !== e.dbz) begin bad++; $display("FAIL %s_dbz got=%b want=%b", e.name, z, e.dbz); end
      lastRes = e.res;
    end
  endtask

  task automatic test_divzero();
    exp_t e; logic [63:0] r; logic z; int lat, busy;
    drive_op(2'b11, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, "divu_by_zero");
    collect(1, r, z, lat, busy);
    e = sb.pop_front();
    total++; if (r !== e.res) begin bad++; $display("FAIL %s_result got=%h want=%h", e.name, r, e.res); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", e.name, lat, e.lat); end
    total++; if (z !== e.dbz) begin bad++; $display("FAIL %s_dbz got=%b want=%b", e.name, z, e.dbz); end
    drive_op(2'b01, 32'd2, 32'd3, 64'd6, 1'b0, "multu_after_dbz");
    total++; if (DivByZeroOut !== 1'b0) begin bad++; $display("FAIL dbz_clear_on_accept got=%b want=0", DivByZeroOut); end
    collect(1, r, z, lat, busy);
    e = sb.pop_front();
    total++; if (r !== e.res) begin bad++; $display("FAIL %s_result got=%h want=%h", e.name, r, e.res); end
    total++; if (z !== e.dbz) begin bad++; $display("FAIL %s_dbz got=%b want=%b", e.name, z, e.dbz); end
    lastRes = e.res;
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [63:0] r; logic [64:0] m; logic z; int lat, busy, dones;
    m = model(2'b01, 32'h12345678, 32'h9ABCDEF0);
    drive_op(2'b01, 32'h12345678, 32'h9ABCDEF0, m[63:0], m[64], "b2b_first");
    repeat (3) begin @(posedge Clk); #1; end
    OpIn = 2'b11; AIn = 32'd1; BIn = 32'd1; StartIn = 1'b1;
    @(posedge Clk); #1;
    StartIn = 1'b0;
    collect(5, r, z, lat, busy);
    e = sb.pop_front();
    total++; if (r !== e.res) begin bad++; $display("FAIL %s_result got=%h want=%h", e.name, r, e.res); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", e.name, lat, e.lat); end
    lastRes = e.res;
    dones = 0;
    repeat (40) begin @(posedge Clk); #1; if (DoneOut) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL b2b_no_second_done got=%0d want=0", dones); end
  endtask

  task automatic test_flush();
    exp_t e; int dones;
    drive_op(2'b11, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b0, "flushed");
    repeat (8) begin @(posedge Clk); #1; end
    FlushIn = 1'b1; StartIn = 1'b1;
    @(posedge Clk); #1;
    FlushIn = 1'b0; StartIn = 1'b0;
    e = sb.pop_back();
    total++; if ({BusyOut, DoneOut} !== 2'b00) begin bad++; $display("FAIL flush_idle got=%b want=00", {BusyOut, DoneOut}); end
    total++; if (ALU64ResultOut !== lastRes) begin bad++; $display("FAIL flush_hold got=%h want=%h", ALU64ResultOut, lastRes); end
    dones = 0;
    repeat (40) begin @(posedge Clk); #1; if (DoneOut) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL flush_no_done got=%0d want=0", dones); end
    OpIn = 2'b01; AIn = 32'd9; BIn = 32'd9; StartIn = 1'b1; FlushIn = 1'b1;
    @(posedge Clk); #1;
    StartIn = 1'b0; FlushIn = 1'b0;
    total++; if (BusyOut !== 1'b0) begin bad++; $display("FAIL flush_beats_start got=%b want=0", BusyOut); end
  endtask

  task automatic test_random();
    exp_t e; logic [63:0] r; logic [64:0] m; logic z; int lat, busy;
    logic [1:0] op; logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 4 == 3) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(0, 300)) : $urandom);
      m = model(op, a, b);
      drive_op(op, a, b, m[63:0], m[64], "rand");
      collect(1, r, z, lat, busy);
      e = sb.pop_front();
      total++; if (r !== e.res) begin bad++; $display("FAIL %s%0d_result op=%0d a=%h b=%h got=%h want=%h", e.name, i, op, a, b, r, e.res); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL %s%0d_latency got=%0d want=%0d", e.name, i, lat, e.lat); end
      total++; if (z !== e.dbz) begin bad++; $display("FAIL %s%0d_dbz got=%b want=%b", e.name, i, z, e.dbz); end
      lastRes = e.res;
    end
  endtask

`ifdef MULDIV_EARLY_OUT_EN
  task automatic test_early();
    exp_t e; logic [63:0] r; logic z; int lat, busy; int want;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin drive_op(2'b01, 32'd3, 32'd5, 64'd15, 1'b0, "early_3x5"); want = 5; end
        1:       begin drive_op(2'b01, 32'd7, 32'd0, 64'd0, 1'b0, "early_7x0"); want = 3; end
        default: begin drive_op(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "early_divu"); want = 34; end
      endcase
      collect(1, r, z, lat, busy);
      e = sb.pop_front();
      total++; if (r !== e.res) begin bad++; $display("FAIL %s_result got=%h want=%h", e.name, r, e.res); end
      total++; if (lat !== want) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", e.name, lat, want); end
      lastRes = e.res;
    end
  endtask
`endif

  task automatic test_async_reset();
    exp_t e;
    drive_op(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1'b0, "reset_mid_op");
    repeat (19) begin @(posedge Clk); #1; end
    total++; if (ALU64ResultOut !== lastRes) begin bad++; $display("FAIL pre_reset_hold got=%h want=%h", ALU64ResultOut, lastRes); end
    #2 Rst_n = 1'b0;
    #1;
    total++;
    if ({BusyOut, DoneOut, DivByZeroOut, ALU64ResultOut} !== 67'd0) begin
      bad++; $display("FAIL async_reset got=%h want=0", {BusyOut, DoneOut, DivByZeroOut, ALU64ResultOut});
    end
    @(negedge Clk) Rst_n = 1'b1;
    repeat (20) begin @(posedge Clk); #1; end
    total++;
    if ({BusyOut, DoneOut, ALU64ResultOut} !== 66'd0) begin
      bad++; $display("FAIL reset_no_partial got=%h want=0", {BusyOut, DoneOut, ALU64ResultOut});
    end
    e = sb.pop_back();
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_divzero();
    test_back_to_back();
    test_flush();
    test_random();
`ifdef MULDIV_EARLY_OUT_EN
    test_early();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
